// File: rtl/load_store_unit_51_if.sv
// rtl/load_store_unit_51_if.sv - request/response and data-memory bundle for load_store_unit_51
interface load_store_unit_51_if;
  logic        req_valid_51;
  logic        req_ready_51;
  logic [2:0]  op_51;
  logic [31:0] addr_51;
  logic [31:0] wdata_in_51;
  logic        resp_valid_51;
  logic        resp_ready_51;
  logic [31:0] resp_data_51;
  logic        resp_err_51;
  logic [31:0] mem_raddr_51;
  logic [31:0] mem_rdata_51;
  logic [31:0] mem_waddr_51;
  logic [31:0] mem_wdata_51;
  logic        mem_write_51;

  modport slave (
    input  req_valid_51, op_51, addr_51, wdata_in_51, resp_ready_51, mem_rdata_51,
    output req_ready_51, resp_valid_51, resp_data_51, resp_err_51,
           mem_raddr_51, mem_waddr_51, mem_wdata_51, mem_write_51
  );

  modport master (
    output req_valid_51, op_51, addr_51, wdata_in_51, resp_ready_51, mem_rdata_51,
    input  req_ready_51, resp_valid_51, resp_data_51, resp_err_51,
           mem_raddr_51, mem_waddr_51, mem_wdata_51, mem_write_51
  );
endinterface

// File: rtl/load_store_unit_51.sv
// rtl/load_store_unit_51.sv - load/store stage with byte/halfword access and read-modify-write sub-word stores
module load_store_unit_51 #(
  parameter logic [31:0] MEM_TOP     = 32'd2000,
  parameter bit          SIGN_EXT_EN = 1'b1
) (
  input logic                  clk_51,
  input logic                  rst_51,
  load_store_unit_51_if.slave  bus
);
  localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                         OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

  state_t      r_state;
  logic [2:0]  r_op;
  logic [1:0]  r_lane;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic        r_resp_err;
  logic [31:0] r_mem_raddr;
  logic [31:0] r_mem_waddr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_write;

  logic [31:0] w_base;
  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_base = {bus.addr_51[31:2], 2'b00};

  always_comb begin
    w_err = (w_base > MEM_TOP);
    case (bus.op_51)
      OP_LW, OP_SW:         if (bus.addr_51[1:0] != 2'b00) w_err = 1'b1;
      OP_LH, OP_LHU, OP_SH: if (bus.addr_51[0])            w_err = 1'b1;
      default: ;
    endcase
  end

  // Lane extraction and merge both work on the combinational memory read in ACCESS.
  always_comb begin
    w_byte = 8'h00;
    case (r_lane)
      2'd0: w_byte = bus.mem_rdata_51[7:0];
      2'd1: w_byte = bus.mem_rdata_51[15:8];
      2'd2: w_byte = bus.mem_rdata_51[23:16];
      2'd3: w_byte = bus.mem_rdata_51[31:24];
      default: ;
    endcase
    w_half = r_lane[1] ? bus.mem_rdata_51[31:16] : bus.mem_rdata_51[15:0];

    w_load = bus.mem_rdata_51;
    case (r_op)
      OP_LH:   w_load = {{16{SIGN_EXT_EN && w_half[15]}}, w_half};
      OP_LHU:  w_load = {16'h0000, w_half};
      OP_LB:   w_load = {{24{SIGN_EXT_EN && w_byte[7]}}, w_byte};
      OP_LBU:  w_load = {24'h000000, w_byte};
      default: ;
    endcase

    w_merge = bus.mem_rdata_51;
    if (r_op == OP_SH) begin
      if (r_lane[1]) w_merge[31:16] = r_wdata[15:0];
      else           w_merge[15:0]  = r_wdata[15:0];
    end else begin
      case (r_lane)
        2'd0: w_merge[7:0]   = r_wdata[7:0];
        2'd1: w_merge[15:8]  = r_wdata[7:0];
        2'd2: w_merge[23:16] = r_wdata[7:0];
        2'd3: w_merge[31:24] = r_wdata[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_51) begin
    if (rst_51) begin
      r_state      <= S_IDLE;
      r_op         <= 3'd0;
      r_lane       <= 2'd0;
      r_base       <= 32'd0;
      r_wdata      <= 32'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'd0;
      r_resp_err   <= 1'b0;
      r_mem_raddr  <= 32'd0;
      r_mem_waddr  <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_write  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid_51) begin
            r_op        <= bus.op_51;
            r_lane      <= bus.addr_51[1:0];
            r_base      <= w_base;
            r_wdata     <= bus.wdata_in_51;
            r_req_ready <= 1'b0;
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= 32'd0;
              r_state      <= S_RESP;
            end else begin
              // Outputs are registered, so ACCESS-cycle bus values are loaded here.
              r_mem_raddr <= w_base;
              if (bus.op_51 == OP_SW) begin
                r_mem_write <= 1'b1;
                r_mem_waddr <= w_base;
                r_mem_wdata <= bus.wdata_in_51;
              end
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          r_mem_raddr <= 32'd0;
          if (r_op == OP_SH || r_op == OP_SB) begin
            r_mem_write <= 1'b1;
            r_mem_waddr <= r_base;
            r_mem_wdata <= w_merge;
            r_state     <= S_WRITE;
          end else begin
            r_mem_write  <= 1'b0;
            r_mem_waddr  <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_resp_data  <= (r_op == OP_SW) ? 32'd0 : w_load;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_WRITE: begin
          r_mem_write  <= 1'b0;
          r_mem_waddr  <= 32'd0;
          r_mem_wdata  <= 32'd0;
          r_resp_data  <= 32'd0;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready_51) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
            r_resp_err   <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_51  = r_req_ready;
  assign bus.resp_valid_51 = r_resp_valid;
  assign bus.resp_data_51  = r_resp_data;
  assign bus.resp_err_51   = r_resp_err;
  assign bus.mem_raddr_51  = r_mem_raddr;
  assign bus.mem_waddr_51  = r_mem_waddr;
  assign bus.mem_wdata_51  = r_mem_wdata;
  assign bus.mem_write_51  = r_mem_write;
endmodule

// File: tb/tb_load_store_unit_51.sv
// tb/tb_load_store_unit_51.sv - directed self-checking bench for load_store_unit_51
module tb_load_store_unit_51;
  logic clk_51 = 1'b0;
  logic rst_51 = 1'b1;
  load_store_unit_51_if bus ();

  load_store_unit_51 #(.MEM_TOP(32'd2000), .SIGN_EXT_EN(1'b1)) dut (
    .clk_51 (clk_51),
    .rst_51 (rst_51),
    .bus    (bus.slave)
  );

  always #5 clk_51 = ~clk_51;

  logic [31:0] mem [0:511];
  int wr_total = 0;
  int total = 0;
  int bad = 0;

  assign bus.mem_rdata_51 = mem[bus.mem_raddr_51[10:2]];

  always @(posedge clk_51) begin
    if (bus.mem_write_51) begin
      mem[bus.mem_waddr_51[10:2]] <= bus.mem_wdata_51;
      wr_total <= wr_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge with the unit idle.
  task automatic txn(input string tag, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wd, input int exp_lat, input logic exp_err,
                     input logic [31:0] exp_data, input int exp_wcyc, input logic [31:0] exp_wdata);
    int k, nw, wcyc, lat;
    logic [31:0] wa, wdv;
    nw = 0; wcyc = 0; lat = 0; wa = 0; wdv = 0;
    bus.req_valid_51 = 1'b1;
    bus.op_51 = op;
    bus.addr_51 = addr;
    bus.wdata_in_51 = wd;
    @(posedge clk_51);
    @(negedge clk_51);
    bus.req_valid_51 = 1'b0;
    k = 1;
    while (k <= 8 && lat == 0) begin
      if (bus.mem_write_51) begin
        nw++; wcyc = k; wa = bus.mem_waddr_51; wdv = bus.mem_wdata_51;
      end
      if (bus.resp_valid_51) lat = k;
      else begin
        @(negedge clk_51);
        k++;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " err"}, {31'd0, bus.resp_err_51}, {31'd0, exp_err});
    chk({tag, " data"}, bus.resp_data_51, exp_data);
    chk({tag, " writes"}, 32'(nw), (exp_wcyc != 0) ? 32'd1 : 32'd0);
    if (exp_wcyc != 0) begin
      chk({tag, " write cycle"}, 32'(wcyc), 32'(exp_wcyc));
      chk({tag, " waddr"}, wa, {addr[31:2], 2'b00});
      chk({tag, " wdata"}, wdv, exp_wdata);
    end
    bus.resp_ready_51 = 1'b1;
    @(posedge clk_51);
    @(negedge clk_51);
    bus.resp_ready_51 = 1'b0;
    chk({tag, " valid after ack"}, {31'd0, bus.resp_valid_51}, 32'd0);
    chk({tag, " ready after ack"}, {31'd0, bus.req_ready_51}, 32'd1);
  endtask

  initial begin
    int wr0, seen, hold_ok;
    logic [31:0] d0;
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    bus.req_valid_51 = 1'b0;
    bus.op_51 = 3'd0;
    bus.addr_51 = 32'd0;
    bus.wdata_in_51 = 32'd0;
    bus.resp_ready_51 = 1'b0;

    repeat (2) @(posedge clk_51);
    @(negedge clk_51);
    rst_51 = 1'b0;
    chk("rst req_ready", {31'd0, bus.req_ready_51}, 32'd1);
    chk("rst resp_valid", {31'd0, bus.resp_valid_51}, 32'd0);
    chk("rst resp_err", {31'd0, bus.resp_err_51}, 32'd0);
    chk("rst mem_write", {31'd0, bus.mem_write_51}, 32'd0);
    chk("rst resp_data", bus.resp_data_51, 32'd0);
    chk("rst mem_raddr", bus.mem_raddr_51, 32'd0);
    chk("rst mem_waddr", bus.mem_waddr_51, 32'd0);
    chk("rst mem_wdata", bus.mem_wdata_51, 32'd0);

    txn("sw 64",   3'd5, 32'h64,  32'hDEADBEEF, 2, 1'b0, 32'h0,        1, 32'hDEADBEEF);
    txn("lw 64",   3'd0, 32'h64,  32'h0,        2, 1'b0, 32'hDEADBEEF, 0, 32'h0);
    txn("sb 65",   3'd7, 32'h65,  32'h000000AA, 3, 1'b0, 32'h0,        2, 32'hDEADAAEF);
    txn("lbu 65",  3'd4, 32'h65,  32'h0,        2, 1'b0, 32'h000000AA, 0, 32'h0);
    txn("lb 65",   3'd3, 32'h65,  32'h0,        2, 1'b0, 32'hFFFFFFAA, 0, 32'h0);
    txn("sh 66",   3'd6, 32'h66,  32'h00001234, 3, 1'b0, 32'h0,        2, 32'h1234AAEF);
    txn("lhu 66",  3'd2, 32'h66,  32'h0,        2, 1'b0, 32'h00001234, 0, 32'h0);
    txn("sh 64",   3'd6, 32'h64,  32'h00008000, 3, 1'b0, 32'h0,        2, 32'h12348000);
    txn("lh 64",   3'd1, 32'h64,  32'h0,        2, 1'b0, 32'hFFFF8000, 0, 32'h0);
    txn("lb 67",   3'd3, 32'h67,  32'h0,        2, 1'b0, 32'h00000012, 0, 32'h0);
    txn("lw 62",   3'd0, 32'h62,  32'h0,        1, 1'b1, 32'h0,        0, 32'h0);
    txn("lh 65",   3'd1, 32'h65,  32'h0,        1, 1'b1, 32'h0,        0, 32'h0);
    txn("sw 7d4",  3'd5, 32'h7D4, 32'h11111111, 1, 1'b1, 32'h0,        0, 32'h0);
    txn("sw 7d0",  3'd5, 32'h7D0, 32'h00000055, 2, 1'b0, 32'h0,        1, 32'h00000055);
    chk("mem 7d0", mem[500], 32'h00000055);

    // Back-pressure: response held while req_valid is pulsed.
    wr0 = wr_total;
    bus.req_valid_51 = 1'b1;
    bus.op_51 = 3'd0;
    bus.addr_51 = 32'h64;
    @(posedge clk_51);
    @(negedge clk_51);
    bus.req_valid_51 = 1'b0;
    seen = 0;
    for (int i = 0; i < 8 && seen == 0; i++) begin
      if (bus.resp_valid_51) seen = 1;
      else @(negedge clk_51);
    end
    chk("hold resp seen", 32'(seen), 32'd1);
    d0 = bus.resp_data_51;
    chk("hold data", d0, 32'h12348000);
    hold_ok = 1;
    for (int i = 0; i < 3; i++) begin
      if (!(bus.resp_valid_51 === 1'b1 && bus.resp_data_51 === d0 && bus.req_ready_51 === 1'b0))
        hold_ok = 0;
      bus.req_valid_51 = (i == 1);
      bus.op_51 = 3'd5;
      bus.addr_51 = 32'h100;
      bus.wdata_in_51 = 32'hFFFFFFFF;
      @(negedge clk_51);
    end
    bus.req_valid_51 = 1'b0;
    chk("hold stable", 32'(hold_ok), 32'd1);
    bus.resp_ready_51 = 1'b1;
    @(posedge clk_51);
    @(negedge clk_51);
    bus.resp_ready_51 = 1'b0;
    chk("hold valid after ack", {31'd0, bus.resp_valid_51}, 32'd0);
    chk("hold ready after ack", {31'd0, bus.req_ready_51}, 32'd1);
    repeat (3) @(negedge clk_51);
    chk("hold pulse no write", 32'(wr_total - wr0), 32'd0);
    chk("hold mem 100", mem[64], 32'd0);
    chk("hold no stray resp", {31'd0, bus.resp_valid_51}, 32'd0);

    // Reset during the ACCESS cycle of a byte store.
    wr0 = wr_total;
    bus.req_valid_51 = 1'b1;
    bus.op_51 = 3'd7;
    bus.addr_51 = 32'h64;
    bus.wdata_in_51 = 32'h00000077;
    @(posedge clk_51);
    @(negedge clk_51);
    bus.req_valid_51 = 1'b0;
    rst_51 = 1'b1;
    @(posedge clk_51);
    @(negedge clk_51);
    rst_51 = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.resp_valid_51 || bus.mem_write_51) seen = 1;
      @(negedge clk_51);
    end
    chk("rst mid no resp/write", 32'(seen), 32'd0);
    chk("rst mid write count", 32'(wr_total - wr0), 32'd0);
    chk("rst mid req_ready", {31'd0, bus.req_ready_51}, 32'd1);
    txn("lw 64 post rst", 3'd0, 32'h64, 32'h0, 2, 1'b0, 32'h12348000, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit_51.md
Name: load_store_unit_51

Overview:
- Memory-access stage that sits between the execute stage and the word-addressed data memory (`data_mem_51`).
- Accepts one load/store request at a time and performs word, halfword and byte accesses.
- Sub-word stores use read-modify-write against the word-wide memory.
- Returns load data or a completion status through a valid/ready response handshake.

Parameters:
- MEM_TOP, 2000, highest valid memory index; any access with word base > MEM_TOP is an error.
- SIGN_EXT_EN, 1, 1 = lb/lh sign-extend; 0 = all loads zero-extend.

Ports:
- clk_51  in  1  clock; all state changes on posedge.
- rst_51  in  1  synchronous, active-high reset.
- req_valid_51  in  1  request present.
- req_ready_51  out  1  unit can accept a request (IDLE only).
- op_51  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
- addr_51  in  32  byte address.
- wdata_in_51  in  32  store data; sh uses [15:0], sb uses [7:0].
- resp_valid_51  out  1  response present.
- resp_ready_51  in  1  consumer accepts response.
- resp_data_51  out  32  extended load data; 0 for stores and errors.
- resp_err_51  out  1  misaligned or out-of-range access.
- mem_raddr_51  out  32  to data memory read address.
- mem_rdata_51  in  32  from data memory (combinational read).
- mem_waddr_51  out  32  to data memory write address.
- mem_wdata_51  out  32  to data memory write data.
- mem_write_51  out  1  to data memory write enable.

Behaviour:
- One clock (clk_51); reset (rst_51) is synchronous and active-high.
- Reset values:
  - State IDLE, req_ready_51 = 1.
  - resp_valid_51, resp_err_51 and mem_write_51 = 0.
  - resp_data_51, mem_raddr_51, mem_waddr_51 and mem_wdata_51 = 0.
- Addressing:
  - Word base = {addr[31:2], 2'b00}; this base drives both mem_raddr_51 and mem_waddr_51.
  - Lane = addr[1:0], little-endian: lane 0 = bits [7:0], lane 3 = bits [31:24]; a halfword at lane 2 = bits [31:16].
- Errors (checked on accept; no memory write ever issued):
  - lw/sw with addr[1:0] != 0.
  - lh/lhu/sh with addr[0] != 0.
  - Word base > MEM_TOP.
- State IDLE:
  - req_ready_51 = 1.
  - On req_valid_51 (handshake at cycle T), register op, addr and data.
  - Error request -> RESP with err = 1 and data = 0 (response visible at T+1).
  - Otherwise -> ACCESS.
- State ACCESS (cycle T+1):
  - mem_raddr_51 = registered base.
  - Loads: capture the lane from mem_rdata_51, extend to 32 bits, register into resp_data_51 -> RESP (valid at T+2).
  - sw: mem_write_51 = 1, mem_wdata_51 = store data -> RESP (valid at T+2).
  - sh/sb: register merged word = mem_rdata_51 with the addressed lane(s) replaced -> WRITE.
- State WRITE (cycle T+2):
  - mem_write_51 = 1, mem_wdata_51 = merged word -> RESP (valid at T+3).
- State RESP:
  - resp_valid_51 = 1; resp_data_51 and resp_err_51 held stable.
  - On resp_ready_51 -> IDLE, with resp_valid_51 = 0 in the next cycle.
  - No new request is accepted in the same cycle as the response handshake.
- mem_write_51 is high for exactly one cycle per successful store and never for loads or errors.
- Outside ACCESS/WRITE, the mem_* outputs are 0.
- req_ready_51 = 0 in every state except IDLE; req_valid_51 is ignored there.
- Reset mid-operation:
  - Next state IDLE and the pending request is dropped; no response is issued.
  - If reset is sampled in ACCESS (sh/sb) or before WRITE, no write occurs and memory is unchanged.
  - A reset sampled in the WRITE cycle does not suppress that cycle's write (memory commits on the same edge).
- Read-after-write: the earliest following load reads in its own ACCESS cycle (≥ 2 cycles after the write edge). It therefore always sees the stored value, including the memory's write settle delay.

Test Plan:
- Reset, then sw addr 0x64, data 0xDEADBEEF -> mem_write_51 = 1 at T+1 with waddr 0x64 and wdata 0xDEADBEEF; response at T+2 with err 0. A following lw 0x64 -> resp_data_51 = 0xDEADBEEF.
- sb addr 0x65, data 0x000000AA -> single write at T+2 of 0xDEADAAEF; response at T+3. Then lbu 0x65 -> 0x000000AA; lb 0x65 -> 0xFFFFFFAA.
- sh addr 0x66, data 0x00001234 -> word becomes 0x1234AAEF; lhu 0x66 -> 0x00001234. Then sh 0x64 with 0x8000 followed by lh 0x64 -> 0xFFFF8000.
- lw 0x62 -> err 1 and data 0 at T+1, mem_write_51 never asserted. sw 0x7D4 -> err 1, no write. sw 0x7D0 -> succeeds.
- Hold resp_ready_51 low for 3 cycles after a lw -> resp_valid_51 and resp_data_51 stay stable, req_ready_51 = 0, and a req_valid_51 pulse is ignored. Raising resp_ready_51 returns the unit to IDLE.
- Assert rst_51 during the ACCESS cycle of sb 0x64 -> no mem_write_51, no response, and a later lw 0x64 returns the prior value.
